// File: rtl/alu_rr_sequencer_pkg.sv
// rtl/alu_rr_sequencer_pkg.sv - opcodes, states and ALU select encodings for the ALU sequencer
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    localparam logic [2:0] SEL_PERSIST = 3'b100;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // The reserved opcode shifts out of the 7-bit field and selects nothing.
    function automatic logic [6:0] op_to_onehot(input logic [2:0] op);
        return 7'(8'd1 << op);
    endfunction

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// rtl/alu_rr_sequencer_if.sv - requester, response and ALU-side signals of the ALU sequencer
interface alu_rr_sequencer_if #(
    parameter int W = 8
);
    logic         on;
    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [2:0]   alu_in_sel;
    logic [6:0]   alu_out_sel;
    logic [W-1:0] alu_num1;
    logic [W-1:0] alu_num2;
    logic [W-1:0] alu_result;
    logic         alu_overflow;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_error;
    logic         busy;

    modport master (
        input  on, req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, alu_overflow, rsp_ready,
        output req0_ready, req1_ready,
        output alu_in_sel, alu_out_sel, alu_num1, alu_num2,
        output rsp_valid, rsp_id, rsp_data, rsp_error, busy
    );

    modport slave (
        output on, req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, alu_overflow, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_in_sel, alu_out_sel, alu_num1, alu_num2,
        input  rsp_valid, rsp_id, rsp_data, rsp_error, busy
    );
endinterface

// File: rtl/alu_rr_sequencer_rr_arb2.sv
// rtl/alu_rr_sequencer_rr_arb2.sv - two-way round-robin picker with a last-grant register
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[0] && req[1]) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // Reset to requester 1 so requester 0 wins the first contested pick.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end
endmodule

// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - shares one registered-operand ALU between two requesters, round-robin
module alu_rr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W       = 8,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_rr_sequencer_if.master bus
);
    localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

    state_t       state;
    state_t       state_nx;
    logic [1:0]   grant;
    logic         arb_en;
    logic         take;
    logic [2:0]   sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [2:0]   op_q;
    logic [2:0]   cnt_q;
    logic [2:0]   in_sel_q;
    logic [6:0]   out_sel_q;
    logic         id_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] rsp_data_q;
    logic         rsp_error_q;

    assign arb_en = (state == ST_IDLE) && bus.on && !rst;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({bus.req1_valid, bus.req0_valid}),
        .en    (arb_en),
        .grant (grant)
    );

    assign take   = |grant;
    assign sel_op = grant[1] ? bus.req1_op : bus.req0_op;
    assign sel_a  = grant[1] ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant[1] ? bus.req1_b  : bus.req0_b;

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.alu_in_sel  = in_sel_q;
    assign bus.alu_out_sel = out_sel_q;
    assign bus.alu_num1    = a_q;
    assign bus.alu_num2    = b_q;
    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.rsp_id      = id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.busy        = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (take) state_nx = (sel_op == OP_RSV) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  if (cnt_q == 3'd0) state_nx = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // ALU controls are registered so the selectors change exactly on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            in_sel_q    <= SEL_RESET;
            out_sel_q   <= '0;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    in_sel_q <= SEL_PERSIST;
                    if (take) begin
                        op_q <= sel_op;
                        id_q <= grant[1];
                        a_q  <= sel_a;
                        b_q  <= (sel_op == OP_NOT) ? '0 : sel_b;
                        if (sel_op == OP_RSV) begin
                            out_sel_q   <= '0;
                            rsp_data_q  <= '0;
                            rsp_error_q <= 1'b1;
                        end else begin
                            in_sel_q  <= SEL_LOAD;
                            out_sel_q <= op_to_onehot(sel_op);
                        end
                    end
                end
                ST_ISSUE: begin
                    in_sel_q <= SEL_PERSIST;
                    cnt_q    <= CNT_INIT;
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        rsp_data_q  <= bus.alu_result;
                        rsp_error_q <= (op_q == OP_MUL) && bus.alu_overflow;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) out_sel_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb/tb_alu_rr_sequencer.sv - directed and randomized self-checking bench for alu_rr_sequencer
module tb_alu_rr_sequencer;
    import alu_seq_pkg::*;

    localparam int W   = 8;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_rr_sequencer_if #(.W(W)) bus ();
    alu_rr_sequencer #(.W(W), .ALU_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ALU stand-in: operands registered on load, result picked by the one-hot select
    logic [W-1:0] r1, r2;
    logic [6:0]   rsel;
    logic [15:0]  prod;
    always @(posedge clk) begin
        if (bus.alu_in_sel == SEL_RESET) begin
            r1 <= '0; r2 <= '0; rsel <= '0;
        end else if (bus.alu_in_sel == SEL_LOAD) begin
            r1 <= bus.alu_num1; r2 <= bus.alu_num2; rsel <= bus.alu_out_sel;
        end
    end
    always_comb begin
        prod = {8'd0, r1} * {8'd0, r2};
        bus.alu_result = '0;
        if (rsel[0]) bus.alu_result = r1 & r2;
        if (rsel[1]) bus.alu_result = r1 | r2;
        if (rsel[2]) bus.alu_result = ~r1;
        if (rsel[3]) bus.alu_result = r1 ^ r2;
        if (rsel[4]) bus.alu_result = r1 + r2;
        if (rsel[5]) bus.alu_result = r1 - r2;
        if (rsel[6]) bus.alu_result = prod[7:0];
        bus.alu_overflow = rsel[6] && (prod[15:8] != 8'd0);
    end

    function automatic int ref_data(input int op, input int a, input int b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return 255 - a;
            3: return a ^ b;
            4: return (a + b) % 256;
            5: return (a - b + 256) % 256;
            6: return (a * b) % 256;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_err(input int op, input int a, input int b);
        if (op == 7) return 1;
        if (op == 6) return (a * b > 255) ? 1 : 0;
        return 0;
    endfunction

    // Transaction-level model: one command in flight, response due a fixed age after grant
    bit started = 0, rst_last = 0, outstanding = 0, last_id = 1, m_id = 0;
    bit e0, e1, ev;
    int age = 0, m_op = 0, m_a = 0, m_b = 0;
    logic [2:0] exp_sel;
    int grants_log[$];
    int xfer_log[$];

    always @(negedge clk) begin
        if (started) begin
            e0 = !rst && !outstanding && bus.on && bus.req0_valid && (!bus.req1_valid || last_id);
            e1 = !rst && !outstanding && bus.on && bus.req1_valid && (!bus.req0_valid || !last_id);
            ev = outstanding && (age >= ((m_op == 7) ? 1 : LAT + 2));
            check("req0_ready", bus.req0_ready, e0);
            check("req1_ready", bus.req1_ready, e1);
            check("busy", bus.busy, outstanding);
            check("rsp_valid", bus.rsp_valid, ev);
            if (rst_last) exp_sel = SEL_RESET;
            else if (outstanding && m_op != 7 && age == 1) exp_sel = SEL_LOAD;
            else exp_sel = SEL_PERSIST;
            check("alu_in_sel", bus.alu_in_sel, exp_sel);
            if (exp_sel == SEL_LOAD) begin
                check("issue_out_sel", bus.alu_out_sel, 32'(1) << m_op);
                check("issue_num1", bus.alu_num1, m_a);
                check("issue_num2", bus.alu_num2, (m_op == 2) ? 0 : m_b);
            end
            if (!outstanding) check("idle_out_sel", bus.alu_out_sel, 0);
            if (ev) begin
                check("rsp_id", bus.rsp_id, m_id);
                check("rsp_data", bus.rsp_data, ref_data(m_op, m_a, m_b));
                check("rsp_error", bus.rsp_error, ref_err(m_op, m_a, m_b));
            end
            if (rst) begin
                outstanding = 0;
                last_id = 1;
            end else if (e0 || e1) begin
                outstanding = 1;
                age = 1;
                m_id = e1;
                m_op = e1 ? int'(bus.req1_op) : int'(bus.req0_op);
                m_a  = e1 ? int'(bus.req1_a)  : int'(bus.req0_a);
                m_b  = e1 ? int'(bus.req1_b)  : int'(bus.req0_b);
                last_id = e1;
                grants_log.push_back(int'(e1));
            end else if (outstanding) begin
                if (ev && bus.rsp_ready) begin
                    outstanding = 0;
                    xfer_log.push_back(int'(m_id) * 512 + ref_err(m_op, m_a, m_b) * 256
                                       + ref_data(m_op, m_a, m_b));
                end else begin
                    age++;
                end
            end
            rst_last = rst;
        end else if (rst) begin
            started = 1; rst_last = 1; outstanding = 0; last_id = 1;
        end
    end

    task automatic do_req(input bit id, input int op, input int a, input int b);
        bit got = 0;
        @(posedge clk); #1;
        if (id) begin
            bus.req1_valid = 1; bus.req1_op = 3'(op); bus.req1_a = 8'(a); bus.req1_b = 8'(b);
        end else begin
            bus.req0_valid = 1; bus.req0_op = 3'(op); bus.req0_a = 8'(a); bus.req0_b = 8'(b);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin got = 1; break; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL grant_timeout: got no ready for id %0d expected a grant", id);
        end
        @(posedge clk); #1;
        if (id) bus.req1_valid = 0; else bus.req0_valid = 0;
    endtask

    task automatic wait_rsp(input string tag, input int id, input int data, input int err,
                            output int n);
        n = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin n = i; break; end
        end
        if (n == 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no rsp_valid expected a response", tag);
        end else begin
            check({tag, "_id"}, bus.rsp_id, id);
            check({tag, "_data"}, bus.rsp_data, data);
            check({tag, "_err"}, bus.rsp_error, err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    int n;
    initial begin
        bus.on = 1; bus.rsp_ready = 1;
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        repeat (3) @(posedge clk);
        #1;
        // contention from reset: AND vs XOR of F0,3C
        bus.req0_valid = 1; bus.req0_op = OP_AND; bus.req0_a = 8'hF0; bus.req0_b = 8'h3C;
        bus.req1_valid = 1; bus.req1_op = OP_XOR; bus.req1_a = 8'hF0; bus.req1_b = 8'h3C;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("reset_in_sel", bus.alu_in_sel, 3'b001);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        for (int i = 0; i < 80 && xfer_log.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (8) @(negedge clk);
        check("t2_count", xfer_log.size() >= 4, 1);
        if (xfer_log.size() >= 4 && grants_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_grant", grants_log[i], i % 2);
                check("t2_xfer", xfer_log[i], (i % 2) ? (512 + 8'hCC) : 8'h30);
            end
        end

        // single ADD
        do_req(0, OP_ADD, 100, 27);
        @(negedge clk);
        check("t1_in_sel", bus.alu_in_sel, 3'b010);
        check("t1_out_sel", bus.alu_out_sel, 7'b0010000);
        wait_rsp("t1", 0, 127, 0, n);
        check("t1_latency", n, LAT + 1);

        // MUL overflow
        do_req(1, OP_MUL, 20, 20);
        wait_rsp("t3", 1, 8'h90, 1, n);

        // backpressure with a competing request pending
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        do_req(0, OP_SUB, 10, 30);
        bus.req1_valid = 1; bus.req1_op = OP_OR; bus.req1_a = 8'h55; bus.req1_b = 8'h0F;
        wait_rsp("t4", 0, 8'hEC, 0, n);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", bus.rsp_valid, 1);
            check("t4_hold_data", bus.rsp_data, 8'hEC);
            check("t4_no_grant", bus.req1_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1;
        do_req(1, OP_OR, 8'h55, 8'h0F);
        wait_rsp("t4b", 1, 8'h5F, 0, n);

        // reserved opcode skips ISSUE
        do_req(0, 7, 5, 9);
        wait_rsp("t4r", 0, 0, 1, n);
        check("t4r_latency", n, 1);
        check("t4r_in_sel", bus.alu_in_sel, SEL_PERSIST);

        // enable low blocks grants
        @(posedge clk); #1;
        bus.on = 0; bus.req0_valid = 1; bus.req0_op = OP_AND;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_off_ready", bus.req0_ready, 0);
            check("t5_off_busy", bus.busy, 0);
        end
        @(posedge clk); #1;
        bus.req0_valid = 0; bus.on = 1;

        // enable dropped mid-operation
        do_req(0, OP_XOR, 8'hAA, 8'h0F);
        @(posedge clk); #1;
        bus.on = 0;
        wait_rsp("t5on", 0, 8'hA5, 0, n);
        @(posedge clk); #1;
        bus.on = 1;

        // reset during WAIT abandons the NOT
        do_req(1, OP_NOT, 8'h3C, 8'hFF);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("t5_rst_valid", bus.rsp_valid, 0);
        check("t5_rst_in_sel", bus.alu_in_sel, 3'b001);
        check("t5_rst_busy", bus.busy, 0);
        repeat (10) @(negedge clk);

        // randomized traffic
        xfer_log.delete();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            rst = ($urandom % 200) == 0;
            bus.on = ($urandom % 8) != 0;
            bus.rsp_ready = ($urandom % 4) != 0;
            bus.req0_valid = $urandom % 2; bus.req0_op = 3'($urandom);
            bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
            bus.req1_valid = $urandom % 2; bus.req1_op = 3'($urandom);
            bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
        end
        @(posedge clk); #1;
        rst = 0; bus.on = 1; bus.rsp_ready = 1; bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (20) @(negedge clk);
        check("rand_activity", xfer_log.size() > 20, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
